// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and formatted load data onto the single
// register-file write port. Optional feature macro: WB_LOAD_BYPASS_EN.
module writeback_arbiter #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [2:0]        mem_funct3,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       pending_mask,
  output logic              regWrite,
  output logic [REG_AW-1:0] writeRegister,
  output logic [DATA_W-1:0] writeData
);
  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;
  logic [LQ_DEPTH-1:0] q_live;
  logic [REG_AW-1:0]   q_rd   [LQ_DEPTH];
  logic [DATA_W-1:0]   q_data [LQ_DEPTH];

  logic              accept;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              push_live;
  logic [DATA_W-1:0] load_data;

  // Byte/halfword selection and extension; undefined funct3 behaves as LW.
  function automatic logic [DATA_W-1:0] format_load(input logic [2:0]        f3,
                                                    input logic [1:0]        off,
                                                    input logic [DATA_W-1:0] w);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{(DATA_W-8){b[7]}}, b};
      3'b001:  r = {{(DATA_W-16){h[15]}}, h};
      3'b100:  r = {{(DATA_W-8){1'b0}}, b};
      3'b101:  r = {{(DATA_W-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign mem_ready = (count < CNT_W'(LQ_DEPTH));
  assign accept    = mem_valid && mem_ready;
  assign pop       = !alu_valid && (count != '0);
  assign load_data = format_load(mem_funct3, mem_addr_lo, mem_rdata);
  // A load racing an ALU write to the same register is already stale.
  assign push_live = !(alu_valid && (alu_rd == mem_rd));

`ifdef WB_LOAD_BYPASS_EN
  assign bypass = accept && !alu_valid && (q_live == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !bypass;

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (q_live[i]) pending_mask = pending_mask | (32'd1 << q_rd[i]);
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      q_live        <= '0;
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else begin
      // Index/data only move on a real write so they stay stable otherwise.
      regWrite <= 1'b0;
      if (alu_valid) begin
        if (alu_rd != '0) begin
          regWrite      <= 1'b1;
          writeRegister <= alu_rd;
          writeData     <= alu_result;
        end
      end else if (bypass) begin
        if (mem_rd != '0) begin
          regWrite      <= 1'b1;
          writeRegister <= mem_rd;
          writeData     <= load_data;
        end
      end else if (pop && q_live[head] && (q_rd[head] != '0)) begin
        regWrite      <= 1'b1;
        writeRegister <= q_rd[head];
        writeData     <= q_data[head];
      end

      for (int i = 0; i < LQ_DEPTH; i++) begin
        if (alu_valid && (q_rd[i] == alu_rd)) q_live[i] <= 1'b0;
      end
      if (pop) begin
        q_live[head] <= 1'b0;
        head         <= head + PTR_W'(1);
      end
      if (push) begin
        q_live[tail] <= push_live;
        tail         <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= mem_rd;
      q_data[tail] <= load_data;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: table of load-format vectors plus
// hand-written ALU-priority, WAW-kill, full-queue, x0 and reset sequences.
module tb_writeback_arbiter;
  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int LQ_DEPTH = 4;
`ifdef WB_LOAD_BYPASS_EN
  localparam int LOAD_LAT = 1;
`else
  localparam int LOAD_LAT = 2;
`endif

  logic              clk;
  logic              rst;
  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [DATA_W-1:0] alu_result;
  logic              mem_valid;
  logic              mem_ready;
  logic [REG_AW-1:0] mem_rd;
  logic [2:0]        mem_funct3;
  logic [1:0]        mem_addr_lo;
  logic [DATA_W-1:0] mem_rdata;
  logic [31:0]       pending_mask;
  logic              regWrite;
  logic [REG_AW-1:0] writeRegister;
  logic [DATA_W-1:0] writeData;

  int total = 0;
  int bad   = 0;
  logic [REG_AW+DATA_W-1:0] exp_q[$];
  logic [REG_AW+DATA_W-1:0] wr_exp;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] exp;
  } ld_vec_t;
  localparam int NV = 14;
  ld_vec_t vecs[NV];
  logic [4:0] full_rd[4];

  writeback_arbiter #(.DATA_W(DATA_W), .REG_AW(REG_AW), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata),
    .pending_mask(pending_mask), .regWrite(regWrite),
    .writeRegister(writeRegister), .writeData(writeData)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // drivers
  task automatic idle();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_result  = '0;
    mem_valid   = 1'b0;
    mem_rd      = '0;
    mem_funct3  = '0;
    mem_addr_lo = '0;
    mem_rdata   = '0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid  = 1'b1;
    alu_rd     = rd;
    alu_result = d;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] off, input logic [31:0] w);
    mem_valid   = 1'b1;
    mem_rd      = rd;
    mem_funct3  = f3;
    mem_addr_lo = off;
    mem_rdata   = w;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  // scoreboard: every register-file write must match the next expected one
  always @(negedge clk) begin
    if (regWrite === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got rd=%0d data=0x%08h, required no write",
                 writeRegister, writeData);
      end else begin
        wr_exp = exp_q.pop_front();
        if ({writeRegister, writeData} !== wr_exp) begin
          bad++;
          $display("FAIL wr_order: got rd=%0d data=0x%08h required rd=%0d data=0x%08h",
                   writeRegister, writeData, wr_exp[DATA_W +: REG_AW], wr_exp[DATA_W-1:0]);
        end
      end
    end
  end

  initial begin
    vecs[0]  = '{3'b000, 2'd3, 32'h80FF_1234, 5'd5,  32'hFFFF_FF80};
    vecs[1]  = '{3'b101, 2'd2, 32'h80FF_1234, 5'd5,  32'h0000_80FF};
    vecs[2]  = '{3'b010, 2'd0, 32'h80FF_1234, 5'd5,  32'h80FF_1234};
    vecs[3]  = '{3'b000, 2'd0, 32'h80FF_1234, 5'd6,  32'h0000_0034};
    vecs[4]  = '{3'b100, 2'd3, 32'h80FF_1234, 5'd7,  32'h0000_0080};
    vecs[5]  = '{3'b001, 2'd2, 32'h80FF_1234, 5'd8,  32'hFFFF_80FF};
    vecs[6]  = '{3'b001, 2'd3, 32'h80FF_1234, 5'd8,  32'hFFFF_80FF};
    vecs[7]  = '{3'b101, 2'd0, 32'h80FF_1234, 5'd9,  32'h0000_1234};
    vecs[8]  = '{3'b000, 2'd1, 32'h80FF_1234, 5'd10, 32'h0000_0012};
    vecs[9]  = '{3'b100, 2'd2, 32'h80FF_1234, 5'd11, 32'h0000_00FF};
    vecs[10] = '{3'b011, 2'd1, 32'hDEAD_BEEF, 5'd12, 32'hDEAD_BEEF};
    vecs[11] = '{3'b110, 2'd3, 32'h8000_0001, 5'd13, 32'h8000_0001};
    vecs[12] = '{3'b001, 2'd1, 32'h0000_7FFF, 5'd14, 32'h0000_7FFF};
    vecs[13] = '{3'b000, 2'd2, 32'hC3A5_5A3C, 5'd31, 32'hFFFF_FFA5};
    full_rd[0] = 5'd12;
    full_rd[1] = 5'd0;
    full_rd[2] = 5'd13;
    full_rd[3] = 5'd14;

    // reset
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_we", 32'(regWrite), 32'd0);
    check("rst_ready", 32'(mem_ready), 32'd1);
    check("rst_pend", pending_mask, 32'd0);
    check("rst_wreg", 32'(writeRegister), 32'd0);
    check("rst_wdata", writeData, 32'd0);
    rst = 1'b0;

    // load formatting and latency through an empty queue
    for (int i = 0; i < NV; i++) begin
      idle();
      drive_load(vecs[i].rd, vecs[i].f3, vecs[i].off, vecs[i].rdata);
      expect_wr(vecs[i].rd, vecs[i].exp);
      cyc();
      idle();
      check("ld_pend_n1", pending_mask, (LOAD_LAT == 1) ? 32'd0 : (32'd1 << vecs[i].rd));
      check("ld_we_n1", 32'(regWrite), (LOAD_LAT == 1) ? 32'd1 : 32'd0);
      if (LOAD_LAT == 2) cyc();
      check("ld_we", 32'(regWrite), 32'd1);
      check("ld_rd", 32'(writeRegister), 32'(vecs[i].rd));
      check("ld_data", writeData, vecs[i].exp);
      cyc();
      check("ld_we_after", 32'(regWrite), 32'd0);
    end

    // ALU priority delays a queued load
    idle();
    drive_load(5'd7, 3'b010, 2'd0, 32'h7777_0007);
    drive_alu(5'd1, 32'h11);
    expect_wr(5'd1, 32'h11);
    expect_wr(5'd2, 32'h22);
    expect_wr(5'd3, 32'h33);
    expect_wr(5'd7, 32'h7777_0007);
    cyc();
    idle();
    drive_alu(5'd2, 32'h22);
    check("pri_pend_a", 32'(pending_mask[7]), 32'd1);
    check("pri_rd1", 32'(writeRegister), 32'd1);
    cyc();
    idle();
    drive_alu(5'd3, 32'h33);
    check("pri_pend_b", 32'(pending_mask[7]), 32'd1);
    check("pri_rd2", 32'(writeRegister), 32'd2);
    cyc();
    idle();
    check("pri_pend_c", 32'(pending_mask[7]), 32'd1);
    check("pri_rd3", 32'(writeRegister), 32'd3);
    cyc();
    check("pri_we7", 32'(regWrite), 32'd1);
    check("pri_rd7", 32'(writeRegister), 32'd7);
    check("pri_data7", writeData, 32'h7777_0007);
    check("pri_pend_d", pending_mask, 32'd0);
    cyc();

    // WAW kill of an already-queued load
    idle();
    drive_load(5'd9, 3'b010, 2'd0, 32'h9999);
    drive_alu(5'd20, 32'h20);
    expect_wr(5'd20, 32'h20);
    cyc();
    idle();
    drive_load(5'd10, 3'b010, 2'd0, 32'hAAAA);
    drive_alu(5'd9, 32'h55);
    expect_wr(5'd9, 32'h55);
    expect_wr(5'd10, 32'hAAAA);
    check("waw_pend_a", pending_mask, 32'd1 << 9);
    cyc();
    idle();
    check("waw_pend_b", pending_mask, 32'd1 << 10);
    check("waw_rd9", 32'(writeRegister), 32'd9);
    check("waw_data9", writeData, 32'h55);
    cyc();
    check("waw_dead_pop", 32'(regWrite), 32'd0);
    check("waw_hold", writeData, 32'h55);
    cyc();
    check("waw_rd10", 32'(writeRegister), 32'd10);
    check("waw_data10", writeData, 32'hAAAA);
    check("waw_pend_c", pending_mask, 32'd0);
    cyc();

    // load killed by an ALU write in the same cycle
    idle();
    drive_load(5'd11, 3'b010, 2'd0, 32'hBBBB);
    drive_alu(5'd11, 32'h11B);
    expect_wr(5'd11, 32'h11B);
    cyc();
    idle();
    check("kill_pend", pending_mask, 32'd0);
    check("kill_rd", 32'(writeRegister), 32'd11);
    cyc();
    check("kill_dead_pop", 32'(regWrite), 32'd0);
    check("kill_hold", writeData, 32'h11B);
    cyc();

    // fill the queue while the ALU keeps the port busy
    for (int i = 0; i < 4; i++) begin
      idle();
      check("full_ready_pre", 32'(mem_ready), 32'd1);
      drive_alu(5'(20 + i), 32'h100 + 32'(i));
      expect_wr(5'(20 + i), 32'h100 + 32'(i));
      drive_load(full_rd[i], 3'b010, 2'd0, 32'hC0 + 32'(i));
      cyc();
    end
    idle();
    check("full_ready", 32'(mem_ready), 32'd0);
    check("full_pend", pending_mask, 32'h0000_7000);
    drive_alu(5'd24, 32'h124);
    drive_load(5'd15, 3'b010, 2'd0, 32'hEE);
    expect_wr(5'd24, 32'h124);
    expect_wr(5'd12, 32'hC0);
    expect_wr(5'd13, 32'hC2);
    expect_wr(5'd14, 32'hC3);
    expect_wr(5'd15, 32'h0F);
    cyc();
    idle();
    drive_load(5'd15, 3'b010, 2'd0, 32'hEE);
    check("full_pop_ready", 32'(mem_ready), 32'd0);
    cyc();
    idle();
    check("full_reopen", 32'(mem_ready), 32'd1);
    check("full_rd12", 32'(writeRegister), 32'd12);
    check("full_data12", writeData, 32'hC0);
    drive_load(5'd15, 3'b010, 2'd0, 32'h0F);
    cyc();
    idle();
    check("x0_no_we", 32'(regWrite), 32'd0);
    check("full_pend_b", pending_mask, (32'd1 << 13) | (32'd1 << 14) | (32'd1 << 15));
    cyc();
    check("full_rd13", 32'(writeRegister), 32'd13);
    cyc();
    check("full_rd14", 32'(writeRegister), 32'd14);
    cyc();
    check("full_rd15", 32'(writeRegister), 32'd15);
    check("full_data15", writeData, 32'h0F);
    cyc();
    check("full_drained_we", 32'(regWrite), 32'd0);
    check("full_drained_pend", pending_mask, 32'd0);

    // ALU write to x0 is suppressed and outputs hold
    idle();
    drive_alu(5'd0, 32'hBAD);
    cyc();
    idle();
    check("alu_x0_we", 32'(regWrite), 32'd0);
    check("alu_x0_rd_hold", 32'(writeRegister), 32'd15);
    check("alu_x0_data_hold", writeData, 32'h0F);
    cyc();

    // reset with loads queued and a write on the outputs
    idle();
    drive_alu(5'd25, 32'h125);
    drive_load(5'd16, 3'b010, 2'd0, 32'h16);
    expect_wr(5'd25, 32'h125);
    cyc();
    idle();
    drive_alu(5'd26, 32'h126);
    drive_load(5'd17, 3'b010, 2'd0, 32'h17);
    expect_wr(5'd26, 32'h126);
    check("mid_pend_a", pending_mask, 32'd1 << 16);
    cyc();
    idle();
    rst = 1'b1;
    check("mid_pend_b", pending_mask, (32'd1 << 16) | (32'd1 << 17));
    check("mid_we_in_rst", 32'(regWrite), 32'd1);
    cyc();
    rst = 1'b0;
    check("mid_we", 32'(regWrite), 32'd0);
    check("mid_pend", pending_mask, 32'd0);
    check("mid_ready", 32'(mem_ready), 32'd1);
    check("mid_wdata", writeData, 32'd0);
    cyc();
    check("mid_no_drain", 32'(regWrite), 32'd0);
    cyc();
    cyc();

    check("wr_all_seen", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
